// File: rtl/framebuffer_arbiter.sv
// Arbitrates one single-port framebuffer BRAM between the packet loader (writer)
// and display scanout (reader); reader-priority with a bounded write-starvation limit.
module framebuffer_arbiter #(
    parameter int unsigned ADDR_W        = 15,
    parameter int unsigned DATA_W        = 64,
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned MAX_RD_STREAK = 4
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              wr_valid_in,
    output logic              wr_ready_out,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] wr_data_in,
    input  logic              rd_valid_in,
    output logic              rd_ready_out,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output logic [DATA_W-1:0] rd_data_out,
    output logic              rd_data_valid_out,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic [DATA_W-1:0] bram_din_out,
    output logic              bram_we_out,
    input  logic [DATA_W-1:0] bram_dout_in,
    output logic [15:0]       wr_count_out,
    output logic              wr_oor_out
);

    localparam int unsigned STREAK_W = 4;
    localparam int unsigned PIPE_W   = READ_LATENCY + 1;

    logic [STREAK_W-1:0] rd_streak;
    logic [PIPE_W-1:0]   rd_pipe;
    logic                streak_room_c;
    logic                rd_grant_c;
    logic                wr_grant_c;
    logic                wr_in_range_c;

    // Reader wins unless it has used up its streak while a write is waiting
    assign streak_room_c = rd_streak < STREAK_W'(MAX_RD_STREAK);
    assign rd_grant_c    = reset_in && rd_valid_in && (!wr_valid_in || streak_room_c);
    assign wr_grant_c    = reset_in && wr_valid_in && !(rd_valid_in && streak_room_c);
    assign wr_in_range_c = 32'(wr_addr_in) < DEPTH;

    assign rd_ready_out      = rd_grant_c;
    assign wr_ready_out      = wr_grant_c;
    assign rd_data_valid_out = rd_pipe[READ_LATENCY];

    // Starvation counter: only meaningful while a write is pending
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            rd_streak <= '0;
        end else if (!wr_valid_in || wr_grant_c) begin
            rd_streak <= '0;
        end else if (rd_grant_c && streak_room_c) begin
            rd_streak <= rd_streak + STREAK_W'(1);
        end
    end

    // BRAM port drive; out-of-range writes are swallowed without touching the port
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            bram_addr_out <= '0;
            bram_din_out  <= '0;
            bram_we_out   <= 1'b0;
            wr_count_out  <= '0;
            wr_oor_out    <= 1'b0;
        end else begin
            bram_we_out <= 1'b0;
            if (wr_grant_c) begin
                if (wr_in_range_c) begin
                    bram_addr_out <= wr_addr_in;
                    bram_din_out  <= wr_data_in;
                    bram_we_out   <= 1'b1;
                    wr_count_out  <= wr_count_out + 16'd1;
                end else begin
                    wr_oor_out <= 1'b1;
                end
            end else if (rd_grant_c) begin
                bram_addr_out <= rd_addr_in;
            end
        end
    end

    // Read return: valid shift pipe, data captured one stage before the pulse
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            rd_pipe     <= '0;
            rd_data_out <= '0;
        end else begin
            rd_pipe <= {rd_pipe[READ_LATENCY-1:0], rd_grant_c};
            if (rd_pipe[READ_LATENCY-1]) begin
                rd_data_out <= bram_dout_in;
            end
        end
    end

endmodule
